// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with a runtime-loadable pattern,
// a valid strobe, selectable overlap and a saturating match counter.
module seq_detect_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Data_in,
  input  logic               en,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [SEQ_LEN-1:0] pattern
);

  localparam int FW = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEQ_LEN-1:0] sh_hist;
  logic [FW-1:0]      sh_fill;
  logic               hit;

  // Candidate history/fill if the current bit is accepted, and the match test.
  always_comb begin
    sh_hist = {hist_q[SEQ_LEN-2:0], Data_in};
    sh_fill = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    hit     = en && !load && (sh_fill == FULL) && (sh_hist == pat_q);
  end

  // Next-state: load beats shift; a load discards any partial sequence.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = sh_hist;
      fill_d = sh_fill;
      if (hit) begin
        out_d = 1'b1;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (OVERLAP == 0) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign pattern     = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: four configurations share stimulus,
// each directed phase checks one of them against hand-computed values.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       Data_in = 1'b0;
  logic [3:0] pat_in = 4'b0000;

  logic       o0, o1, o2, o3;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;
  logic [3:0] p0, p1, p2, p3;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    int    sel;
    bit    xo;
    int    xc;
    int    xp;
    string nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .Data_in(Data_in), .en(en), .load(load),
    .pat_in(pat_in), .out(o0), .match_count(c0), .pattern(p0));

  seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .Data_in(Data_in), .en(en), .load(load),
    .pat_in(pat_in), .out(o1), .match_count(c1), .pattern(p1));

  seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .Data_in(Data_in), .en(en), .load(load),
    .pat_in(pat_in), .out(o2), .match_count(c2), .pattern(p2));

  seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b0000), .OVERLAP(1), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .Data_in(Data_in), .en(en), .load(load),
    .pat_in(pat_in), .out(o3), .match_count(c3), .pattern(p3));

  task automatic st(input int s, input bit r, input bit e, input bit ld,
                    input bit d, input logic [3:0] p, input bit xo,
                    input int xc, input int xp, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = ld; Data_in = d; pat_in = p;
    x.sel = s; x.xo = xo; x.xc = xc; x.xp = xp; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic rs(input int s, input int xp, input string nm);
    st(s, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, xp, nm);
  endtask

  task automatic bt(input int s, input bit d, input bit xo, input int xc,
                    input string nm);
    st(s, 1'b0, 1'b1, 1'b0, d, 4'b0000, xo, xc, -1, nm);
  endtask

  task automatic idl(input int s, input int xc, input string nm);
    st(s, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, xc, -1, nm);
  endtask

  // Monitor: pops one expectation per clock and compares the chosen DUT.
  exp_t        ex;
  logic        ao;
  logic [31:0] ac;
  logic [3:0]  ap;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        case (ex.sel)
          0: begin ao = o0; ac = {24'd0, c0}; ap = p0; end
          1: begin ao = o1; ac = {24'd0, c1}; ap = p1; end
          2: begin ao = o2; ac = {30'd0, c2}; ap = p2; end
          default: begin ao = o3; ac = {24'd0, c3}; ap = p3; end
        endcase
        n_run++;
        if (ao !== ex.xo) begin
          n_fail++;
          $display("FAIL %s out got %b want %b", ex.nm, ao, ex.xo);
        end
        if (ex.xc >= 0) begin
          n_run++;
          if (ac !== 32'(ex.xc)) begin
            n_fail++;
            $display("FAIL %s count got %0d want %0d", ex.nm, ac, ex.xc);
          end
        end
        if (ex.xp >= 0) begin
          n_run++;
          if (ap !== 4'(ex.xp)) begin
            n_fail++;
            $display("FAIL %s pattern got %b want %b", ex.nm, ap, 4'(ex.xp));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog run got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: overlapping 1011 on u0
    rs(0, 4'b1011, "t1_rst");
    bt(0, 1, 0, 0, "t1_b1");
    bt(0, 0, 0, 0, "t1_b2");
    bt(0, 1, 0, 0, "t1_b3");
    bt(0, 1, 1, 1, "t1_b4");
    bt(0, 0, 0, 1, "t1_b5");
    bt(0, 1, 0, 1, "t1_b6");
    bt(0, 1, 1, 2, "t1_b7");
    bt(0, 0, 0, 2, "t1_b8");
    bt(0, 1, 0, 2, "t1_b9");
    idl(0, 2, "t1_idle");
    // 2: same stream, non-overlap u1
    rs(1, 4'b1011, "t2_rst");
    bt(1, 1, 0, 0, "t2_b1");
    bt(1, 0, 0, 0, "t2_b2");
    bt(1, 1, 0, 0, "t2_b3");
    bt(1, 1, 1, 1, "t2_b4");
    bt(1, 0, 0, 1, "t2_b5");
    bt(1, 1, 0, 1, "t2_b6");
    bt(1, 1, 0, 1, "t2_b7");
    bt(1, 0, 0, 1, "t2_b8");
    bt(1, 1, 0, 1, "t2_b9");
    idl(1, 1, "t2_idle");
    // 3: en gaps do not break a partial sequence
    rs(0, 4'b1011, "t3_rst");
    bt(0, 1, 0, 0, "t3_b1");
    bt(0, 0, 0, 0, "t3_b2");
    idl(0, 0, "t3_gap1");
    idl(0, 0, "t3_gap2");
    idl(0, 0, "t3_gap3");
    bt(0, 1, 0, 0, "t3_b3");
    bt(0, 1, 1, 1, "t3_b4");
    idl(0, 1, "t3_idle");
    // 4: runtime load, then load with en set mid-stream
    st(0, 0, 0, 1, 0, 4'b0110, 0, 1, 4'b0110, "t4_load");
    bt(0, 0, 0, 1, "t4_b1");
    bt(0, 1, 0, 1, "t4_b2");
    bt(0, 1, 0, 1, "t4_b3");
    bt(0, 0, 1, 2, "t4_b4");
    st(0, 0, 1, 1, 0, 4'b0110, 0, 2, 4'b0110, "t4_load_en");
    bt(0, 1, 0, 2, "t4_c1");
    bt(0, 1, 0, 2, "t4_c2");
    bt(0, 0, 0, 2, "t4_c3");
    // 5: reset mid-sequence, including on a would-be hit edge
    rs(0, 4'b1011, "t5_rst");
    bt(0, 1, 0, 0, "t5_b1");
    bt(0, 0, 0, 0, "t5_b2");
    bt(0, 1, 0, 0, "t5_b3");
    st(0, 1, 1, 0, 1, 4'b0000, 0, 0, 4'b1011, "t5_rst_hit");
    bt(0, 1, 0, 0, "t5_lone1");
    bt(0, 1, 0, 0, "t5_d1");
    bt(0, 0, 0, 0, "t5_d2");
    bt(0, 1, 0, 0, "t5_d3");
    bt(0, 1, 1, 1, "t5_d4");
    // 6a: counter saturation with CNT_W=2
    rs(2, 4'b1011, "t6_rst");
    bt(2, 1, 0, 0, "t6_a1");
    bt(2, 0, 0, 0, "t6_a2");
    bt(2, 1, 0, 0, "t6_a3");
    bt(2, 1, 1, 1, "t6_h1");
    for (int k = 0; k < 4; k++) begin
      bt(2, 0, 0, (k + 1 > 3) ? 3 : k + 1, "t6_z");
      bt(2, 1, 0, (k + 1 > 3) ? 3 : k + 1, "t6_o");
      bt(2, 1, 1, (k + 2 > 3) ? 3 : k + 2, "t6_h");
    end
    idl(2, 3, "t6_idle");
    // 6b: all-zero pattern needs four real bits after reset
    rs(3, 4'b0000, "t7_rst");
    idl(3, 0, "t7_idle");
    bt(3, 0, 0, 0, "t7_b1");
    bt(3, 0, 0, 0, "t7_b2");
    bt(3, 0, 0, 0, "t7_b3");
    bt(3, 0, 1, 1, "t7_b4");
    bt(3, 0, 1, 2, "t7_b5");
    idl(3, 2, "t7_end");
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
